// File: rtl/bf_sweep_checker.sv
// rtl/bf_sweep_checker.sv - exhaustive 3-input sweep checker for a combinational function block
//
// Drives {a,b,c} through vectors 0..7. Each vector is held for HOLD_CYCLES
// cycles and then sampled for one cycle. The sampled x values are compared
// against an expected truth table that is latched when start is accepted.
//
// Parameters:
//   HOLD_CYCLES   cycles each vector is held before x is sampled (1..255)
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         one-cycle run request, honoured in IDLE or DONE only
//   expected      expected truth table, bit i = x for {a,b,c}=i
//   x_in          output x of the block under check
//   a, b, c       registered stimulus, vector index bits 2/1/0
//   busy          high while the sweep runs (DRIVE or SAMPLE)
//   done          level, high in DONE
//   pass          done with zero mismatches
//   captured      sampled x per vector
//   mismatch_cnt  number of vectors whose x differed from expected (0..8)
module bf_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       x_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [3:0] mismatch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] cap_q, cap_d;
  logic [3:0] mis_q, mis_d;
  logic [2:0] abc_q, abc_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      hold_q  <= 8'd0;
      exp_q   <= 8'h00;
      cap_q   <= 8'h00;
      mis_q   <= 4'd0;
      abc_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mis_q   <= mis_d;
      abc_q   <= abc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
      S_DRIVE:        if (hold_q == HOLD_LAST) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = (idx_q == 3'd7) ? S_DONE : S_DRIVE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    exp_d  = exp_q;
    cap_d  = cap_q;
    mis_d  = mis_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d  = 3'd0;
          hold_d = 8'd0;
          exp_d  = expected;
          cap_d  = 8'h00;
          mis_d  = 4'd0;
        end
      end
      S_DRIVE: hold_d = hold_q + 8'd1;
      S_SAMPLE: begin
        cap_d[idx_q] = x_in;
        if (x_in != exp_q[idx_q]) mis_d = mis_q + 4'd1;
        if (idx_q != 3'd7) begin
          idx_d  = idx_q + 3'd1;
          hold_d = 8'd0;
        end
      end
      default: ;
    endcase
    // Stimulus is registered: load it from the upcoming state and index so
    // the pins line up with the state the block is entering.
    abc_d = (state_d == S_DRIVE || state_d == S_SAMPLE) ? idx_d : 3'd0;
  end

  // Outputs
  always_comb begin
    busy         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done         = (state_q == S_DONE);
    pass         = done && (mis_q == 4'd0);
    a            = abc_q[2];
    b            = abc_q[1];
    c            = abc_q[0];
    captured     = cap_q;
    mismatch_cnt = mis_q;
  end

endmodule
